control_unit: RTL and testbench
===============================

CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 SHALL have port clk, input, 1 bit: the single system clock; all state changes occur on its rising edge.
REQ-002 SHALL have port clr, input, 1 bit: asynchronous, active-low reset.
REQ-003 SHALL have port IR_Data, input, 32 bits: instruction register contents; opcode [31:27], Ra [26:23], Rb [22:19], Rc [18:15].
REQ-004 SHALL have port mem_rdy, input, 1 bit: memory read data valid on Mdatain.
REQ-005 SHALL have ports PC_out, PC_in, IncPC, MAR_in, MDR_in, MDR_out, Read, IR_in, Y_in, Z_in and Zlow_out, each an output of 1 bit: datapath strobes.
REQ-006 SHALL have ports R_in and R_out, each an output of 16 bits: one-hot general-register load and drive selects.
REQ-007 SHALL have port alu_instruction, output, 5 bits: ALU operation code.
REQ-008 SHALL have port run, output, 1 bit: processor running (0 once halted).
REQ-009 SHALL have port illegal, output, 1 bit: one-cycle pulse on an unsupported opcode.
REQ-010 SHALL have port instr_count, output, 16 bits: count of retired instructions.

Function
REQ-011 SHALL implement states T0, T1, T2, T3, T4, T5 and HALT, with one state per clock.
REQ-012 SHALL derive all strobes combinationally from the current state and IR_Data; strobes are valid for the whole cycle and the datapath samples them on the closing edge.
REQ-013 In T0, SHALL assert PC_out, MAR_in, IncPC and Z_in; next state T1.
REQ-014 In T1, SHALL assert Zlow_out, PC_in, Read and MDR_in.
- Stays in T1 while mem_rdy=0, with the same strobes held (the PC reload is idempotent).
- Goes to T2 on mem_rdy=1.
REQ-015 In T2, SHALL assert MDR_out and IR_in; next state T3.
REQ-016 Three-register ALU opcodes are 00011 through 01011 (add, sub, and, or, shr, shra, shl, ror, rol).
- T3: R_out[Rb] and Y_in.
- T4: R_out[Rc], alu_instruction equal to the opcode, and Z_in.
- T5: Zlow_out and R_in[Ra].
REQ-017 Unary opcodes are 10001 (neg) and 10010 (not).
- T3: no strobes.
- T4: R_out[Rb], alu_instruction equal to the opcode, and Z_in.
- T5: Zlow_out and R_in[Ra].
REQ-018 From T3, SHALL go to T4 for ALU and unary opcodes; to T0 for nop (11010); to HALT for halt (11011); otherwise to T0 with illegal=1 during that T3.
REQ-019 T4 SHALL always go to T5, and T5 SHALL always go to T0.
REQ-020 In HALT, SHALL assert no strobes, drive run=0, and remain in HALT until reset.
REQ-021 Outside T4, SHALL drive alu_instruction to 5'b00000.
- R_in and R_out are all-zero except where REQ-016/REQ-017 name a register.
- At most one bit of each is set.
REQ-022 SHALL never assert two bus drivers (PC_out, MDR_out, Zlow_out, any R_out) in the same cycle.
REQ-023 SHALL increment instr_count by 1 on leaving T5, on T3→T0 for nop, and on T3→HALT; illegal opcodes are not counted.
- Wraps from 0xFFFF to 0x0000.
REQ-024 Latency: an ALU or unary instruction takes 6 cycles, and nop takes 4 cycles, when mem_rdy=1 in T1; each T1 wait cycle adds 1.

Reset
REQ-025 On clr=0, SHALL immediately enter T0 with instr_count=0, run=1 and illegal=0, abandoning any instruction in flight, including one in T1 wait or in HALT.
REQ-026 After reset, SHALL drive the T0 strobes (PC_out, MAR_in, IncPC, Z_in), with all other strobes, R_in, R_out and alu_instruction at 0.
REQ-027 SHALL advance to T1 on the first rising clk edge after clr returns to 1.

Structure
REQ-028 SHALL take opcode constants, the state encoding and the IR field bit positions from the shared package minisrc_pkg.
REQ-029 SHALL instantiate reg_decoder_4to16 (4-bit register field to 16-bit one-hot, with enable) twice: once for R_in and once for R_out.

Verification
REQ-030 Shr: IR=0x389A8000, R3=0x8000FA92, R5=0xA.
- T3: R_out=0x0008. T4: R_out=0x0020 and alu_instruction=00111.
- T5: R_in=0x0002, and R1 becomes 0x0020003E.
- Total 6 cycles; instr_count +1.
REQ-031 Memory wait: mem_rdy=0 for 3 cycles in T1 → remains in T1 with Read=1 and MDR_in=1; the instruction completes in 9 cycles.
REQ-032 Unary: IR with opcode 10001, Ra=2, Rb=4 → T3 has no strobes; T4: R_out=0x0010; T5: R_in=0x0004.
REQ-033 Control opcodes:
- Nop → T3 is followed by T0 (4 cycles).
- Opcode 11111 → illegal pulses for 1 cycle and instr_count is unchanged.
- Halt → run falls to 0, no strobes thereafter, and clr=0 restores T0 with run=1.
REQ-034 Reset during T4: drive clr=0 → T0 immediately, Z_in from T0 only, no R_in asserted, and instr_count=0.
REQ-035 Counter wrap: preload with 0xFFFF retired nops → the next retire reads 0x0000; bus-driver exclusivity is asserted on every cycle.

Source files
------------

// File: rtl/minisrc_pkg.sv
// Shared definitions for the mini SRC control path: state encoding,
// opcode constants, IR field positions and opcode class helpers.
package minisrc_pkg;

  typedef enum logic [2:0] {
    T0   = 3'd0,
    T1   = 3'd1,
    T2   = 3'd2,
    T3   = 3'd3,
    T4   = 3'd4,
    T5   = 3'd5,
    HALT = 3'd6
  } state_t;

  localparam int OP_MSB = 31;
  localparam int OP_LSB = 27;
  localparam int RA_MSB = 26;
  localparam int RA_LSB = 23;
  localparam int RB_MSB = 22;
  localparam int RB_LSB = 19;
  localparam int RC_MSB = 18;
  localparam int RC_LSB = 15;

  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_SHR  = 5'b00111;
  localparam logic [4:0] OP_SHRA = 5'b01000;
  localparam logic [4:0] OP_SHL  = 5'b01001;
  localparam logic [4:0] OP_ROR  = 5'b01010;
  localparam logic [4:0] OP_ROL  = 5'b01011;
  localparam logic [4:0] OP_NEG  = 5'b10001;
  localparam logic [4:0] OP_NOT  = 5'b10010;
  localparam logic [4:0] OP_NOP  = 5'b11010;
  localparam logic [4:0] OP_HALT = 5'b11011;

  // Three-register ALU ops occupy one contiguous opcode range.
  function automatic logic is_alu3(input logic [4:0] op);
    return (op >= OP_ADD) && (op <= OP_ROL);
  endfunction

  function automatic logic is_unary(input logic [4:0] op);
    return (op == OP_NEG) || (op == OP_NOT);
  endfunction

endpackage

// File: rtl/control_unit_if.sv
// Datapath-facing signal bundle of the control unit: instruction and memory
// status in, datapath strobes, register selects and status out.
interface control_unit_if;
  logic [31:0] IR_Data;
  logic        mem_rdy;
  logic        PC_out;
  logic        PC_in;
  logic        IncPC;
  logic        MAR_in;
  logic        MDR_in;
  logic        MDR_out;
  logic        Read;
  logic        IR_in;
  logic        Y_in;
  logic        Z_in;
  logic        Zlow_out;
  logic [15:0] R_in;
  logic [15:0] R_out;
  logic [4:0]  alu_instruction;
  logic        run;
  logic        illegal;
  logic [15:0] instr_count;

  // Datapath side
  modport master (
    output IR_Data, mem_rdy,
    input  PC_out, PC_in, IncPC, MAR_in, MDR_in, MDR_out, Read, IR_in,
           Y_in, Z_in, Zlow_out, R_in, R_out, alu_instruction,
           run, illegal, instr_count
  );

  // Control unit side
  modport slave (
    input  IR_Data, mem_rdy,
    output PC_out, PC_in, IncPC, MAR_in, MDR_in, MDR_out, Read, IR_in,
           Y_in, Z_in, Zlow_out, R_in, R_out, alu_instruction,
           run, illegal, instr_count
  );
endinterface

// File: rtl/reg_decoder_4to16.sv
// 4-bit register field to 16-bit one-hot select; all zero when disabled.
module reg_decoder_4to16 (
  input  logic [3:0]  sel,
  input  logic        en,
  output logic [15:0] onehot
);

  // One-hot decode gated by enable
  always_comb begin
    onehot = '0;
    if (en) onehot[sel] = 1'b1;
  end

endmodule

// File: rtl/control_unit.sv
// Mini SRC control unit: fetch/decode/execute sequencer producing
// datapath strobes, one-hot register selects and a retired-instruction count.
//
// state | meaning
// T0    | PC to MAR, start PC increment into Z
// T1    | reload PC from Z, memory read into MDR; waits for mem_rdy
// T2    | MDR to IR
// T3    | decode; ALU ops load Y from Rb; nop/halt retire; illegal flagged
// T4    | ALU operation into Z (operand Rc for 3-reg ops, Rb for unary)
// T5    | Z low to Ra, instruction retires
// HALT  | stopped, no strobes until reset
module control_unit
  import minisrc_pkg::*;
(
  input logic           clk,
  input logic           clr,
  control_unit_if.slave bus
);

  state_t      state;
  state_t      state_nxt;
  logic [15:0] count_q;
  logic [4:0]  opcode;
  logic [3:0]  ra;
  logic [3:0]  rb;
  logic [3:0]  rc;
  logic        op_alu;
  logic        op_unary;
  logic        retire;
  logic        rout_en;
  logic [3:0]  rout_sel;
  logic        rin_en;
  logic [15:0] r_in_dec;
  logic [15:0] r_out_dec;
  logic        unused_ir;

  assign opcode    = bus.IR_Data[OP_MSB:OP_LSB];
  assign ra        = bus.IR_Data[RA_MSB:RA_LSB];
  assign rb        = bus.IR_Data[RB_MSB:RB_LSB];
  assign rc        = bus.IR_Data[RC_MSB:RC_LSB];
  assign unused_ir = ^bus.IR_Data[RC_LSB-1:0];
  assign op_alu    = is_alu3(opcode);
  assign op_unary  = is_unary(opcode);

  // State register
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) state <= T0;
    else      state <= state_nxt;
  end

  // Retired-instruction counter, wraps naturally at 16 bits
  always_ff @(posedge clk or negedge clr) begin
    if (!clr)        count_q <= '0;
    else if (retire) count_q <= count_q + 16'd1;
  end

  // Next state and strobes from current state and IR
  always_comb begin
    state_nxt           = state;
    retire              = 1'b0;
    rout_en             = 1'b0;
    rout_sel            = rb;
    rin_en              = 1'b0;
    bus.PC_out          = 1'b0;
    bus.PC_in           = 1'b0;
    bus.IncPC           = 1'b0;
    bus.MAR_in          = 1'b0;
    bus.MDR_in          = 1'b0;
    bus.MDR_out         = 1'b0;
    bus.Read            = 1'b0;
    bus.IR_in           = 1'b0;
    bus.Y_in            = 1'b0;
    bus.Z_in            = 1'b0;
    bus.Zlow_out        = 1'b0;
    bus.alu_instruction = 5'b00000;
    bus.illegal         = 1'b0;
    case (state)
      T0: begin
        bus.PC_out = 1'b1;
        bus.MAR_in = 1'b1;
        bus.IncPC  = 1'b1;
        bus.Z_in   = 1'b1;
        state_nxt  = T1;
      end
      T1: begin
        // Holding these while waiting is harmless: PC reload is idempotent.
        bus.Zlow_out = 1'b1;
        bus.PC_in    = 1'b1;
        bus.Read     = 1'b1;
        bus.MDR_in   = 1'b1;
        if (bus.mem_rdy) state_nxt = T2;
      end
      T2: begin
        bus.MDR_out = 1'b1;
        bus.IR_in   = 1'b1;
        state_nxt   = T3;
      end
      T3: begin
        if (op_alu) begin
          bus.Y_in  = 1'b1;
          rout_en   = 1'b1;
          rout_sel  = rb;
          state_nxt = T4;
        end else if (op_unary) begin
          state_nxt = T4;
        end else if (opcode == OP_NOP) begin
          retire    = 1'b1;
          state_nxt = T0;
        end else if (opcode == OP_HALT) begin
          retire    = 1'b1;
          state_nxt = HALT;
        end else begin
          bus.illegal = 1'b1;
          state_nxt   = T0;
        end
      end
      T4: begin
        bus.Z_in            = 1'b1;
        bus.alu_instruction = opcode;
        rout_en             = op_alu | op_unary;
        rout_sel            = op_alu ? rc : rb;
        state_nxt           = T5;
      end
      T5: begin
        bus.Zlow_out = 1'b1;
        rin_en       = op_alu | op_unary;
        retire       = 1'b1;
        state_nxt    = T0;
      end
      HALT: state_nxt = HALT;
      default: state_nxt = T0;
    endcase
  end

  reg_decoder_4to16 u_rin_dec (
    .sel    (ra),
    .en     (rin_en),
    .onehot (r_in_dec)
  );

  reg_decoder_4to16 u_rout_dec (
    .sel    (rout_sel),
    .en     (rout_en),
    .onehot (r_out_dec)
  );

  assign bus.R_in        = r_in_dec;
  assign bus.R_out       = r_out_dec;
  assign bus.run         = (state != HALT);
  assign bus.instr_count = count_q;

endmodule

// File: tb/tb_control_unit.sv
// Directed bench for control_unit: per-cycle strobe/select checks against
// hand-derived vectors, plus a per-cycle bus-driver exclusivity monitor.
module tb_control_unit;
  import minisrc_pkg::*;

  // {PC_out,PC_in,IncPC,MAR_in,MDR_in,MDR_out,Read,IR_in,Y_in,Z_in,Zlow_out}
  localparam logic [10:0] S_NONE = 11'b00000000000;
  localparam logic [10:0] S_T0   = 11'b10110000010;
  localparam logic [10:0] S_T1   = 11'b01001010001;
  localparam logic [10:0] S_T2   = 11'b00000101000;
  localparam logic [10:0] S_Y    = 11'b00000000100;
  localparam logic [10:0] S_Z    = 11'b00000000010;
  localparam logic [10:0] S_ZLOW = 11'b00000000001;

  logic clk = 1'b0;
  logic clr;
  int   checks   = 0;
  int   failures = 0;
  logic excl_on  = 1'b0;

  control_unit_if bus ();

  control_unit dut (
    .clk (clk),
    .clr (clr),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [10:0] strobes();
    return {bus.PC_out, bus.PC_in, bus.IncPC, bus.MAR_in, bus.MDR_in, bus.MDR_out,
            bus.Read, bus.IR_in, bus.Y_in, bus.Z_in, bus.Zlow_out};
  endfunction

  function automatic logic [31:0] mk_ir(input logic [4:0] op, input logic [3:0] ra,
                                        input logic [3:0] rb, input logic [3:0] rc);
    return {op, ra, rb, rc, 15'd0};
  endfunction

  // Check one cycle's outputs, then advance to the next falling edge
  task automatic cyc(input string tag, input logic [10:0] s, input logic [15:0] rin,
                     input logic [15:0] rout, input logic [4:0] alu);
    check({tag, ".strobes"}, 32'(strobes()), 32'(s));
    check({tag, ".r_in"}, 32'(bus.R_in), 32'(rin));
    check({tag, ".r_out"}, 32'(bus.R_out), 32'(rout));
    check({tag, ".alu"}, 32'(bus.alu_instruction), 32'(alu));
    @(negedge clk);
  endtask

  task automatic fetch(input string tag);
    cyc({tag, ".t0"}, S_T0, 16'h0, 16'h0, 5'd0);
    cyc({tag, ".t1"}, S_T1, 16'h0, 16'h0, 5'd0);
    cyc({tag, ".t2"}, S_T2, 16'h0, 16'h0, 5'd0);
  endtask

  // At most one bus driver in any cycle
  always @(negedge clk) begin
    if (excl_on)
      check("bus_excl",
            32'((int'(bus.PC_out) + int'(bus.MDR_out) + int'(bus.Zlow_out)
                 + $countones(bus.R_out)) <= 1), 32'd1);
  end

  initial begin
    clr = 1'b0;
    bus.IR_Data = 32'h0;
    bus.mem_rdy = 1'b1;
    repeat (2) @(negedge clk);

    check("rst.strobes", 32'(strobes()), 32'(S_T0));
    check("rst.r_in", 32'(bus.R_in), 32'h0);
    check("rst.r_out", 32'(bus.R_out), 32'h0);
    check("rst.alu", 32'(bus.alu_instruction), 32'h0);
    check("rst.run", 32'(bus.run), 32'h1);
    check("rst.illegal", 32'(bus.illegal), 32'h0);
    check("rst.count", 32'(bus.instr_count), 32'h0);
    clr = 1'b1;
    excl_on = 1'b1;

    // shr R1, R3, R5
    bus.IR_Data = 32'h389A8000;
    fetch("shr");
    cyc("shr.t3", S_Y, 16'h0000, 16'h0008, 5'd0);
    cyc("shr.t4", S_Z, 16'h0000, 16'h0020, 5'b00111);
    cyc("shr.t5", S_ZLOW, 16'h0002, 16'h0000, 5'd0);
    check("shr.back_t0", 32'(strobes()), 32'(S_T0));
    check("shr.count", 32'(bus.instr_count), 32'd1);

    // add R7, R2, R9 with three memory wait cycles
    bus.IR_Data = mk_ir(5'b00011, 4'd7, 4'd2, 4'd9);
    bus.mem_rdy = 1'b0;
    cyc("wait.t0", S_T0, 16'h0, 16'h0, 5'd0);
    cyc("wait.t1a", S_T1, 16'h0, 16'h0, 5'd0);
    cyc("wait.t1b", S_T1, 16'h0, 16'h0, 5'd0);
    cyc("wait.t1c", S_T1, 16'h0, 16'h0, 5'd0);
    bus.mem_rdy = 1'b1;
    cyc("wait.t1d", S_T1, 16'h0, 16'h0, 5'd0);
    cyc("wait.t2", S_T2, 16'h0, 16'h0, 5'd0);
    cyc("wait.t3", S_Y, 16'h0000, 16'h0004, 5'd0);
    cyc("wait.t4", S_Z, 16'h0000, 16'h0200, 5'b00011);
    cyc("wait.t5", S_ZLOW, 16'h0080, 16'h0000, 5'd0);
    check("wait.back_t0", 32'(strobes()), 32'(S_T0));
    check("wait.count", 32'(bus.instr_count), 32'd2);

    // neg R2, R4
    bus.IR_Data = mk_ir(5'b10001, 4'd2, 4'd4, 4'd15);
    fetch("neg");
    cyc("neg.t3", S_NONE, 16'h0000, 16'h0000, 5'd0);
    cyc("neg.t4", S_Z, 16'h0000, 16'h0010, 5'b10001);
    cyc("neg.t5", S_ZLOW, 16'h0004, 16'h0000, 5'd0);
    check("neg.count", 32'(bus.instr_count), 32'd3);

    // nop: four cycles
    bus.IR_Data = mk_ir(5'b11010, 4'd1, 4'd2, 4'd3);
    fetch("nop");
    check("nop.illegal", 32'(bus.illegal), 32'h0);
    cyc("nop.t3", S_NONE, 16'h0, 16'h0, 5'd0);
    check("nop.back_t0", 32'(strobes()), 32'(S_T0));
    check("nop.count", 32'(bus.instr_count), 32'd4);

    // illegal opcode 11111
    bus.IR_Data = mk_ir(5'b11111, 4'd1, 4'd2, 4'd3);
    fetch("ill");
    check("ill.pulse", 32'(bus.illegal), 32'h1);
    cyc("ill.t3", S_NONE, 16'h0, 16'h0, 5'd0);
    check("ill.pulse_end", 32'(bus.illegal), 32'h0);
    check("ill.back_t0", 32'(strobes()), 32'(S_T0));
    check("ill.count", 32'(bus.instr_count), 32'd4);

    // rol aborted by reset during T4
    bus.IR_Data = mk_ir(5'b01011, 4'd3, 4'd1, 4'd2);
    fetch("rst4");
    cyc("rst4.t3", S_Y, 16'h0000, 16'h0002, 5'd0);
    check("rst4.t4_alu", 32'(bus.alu_instruction), 32'(5'b01011));
    clr = 1'b0;
    #1;
    check("rst4.strobes", 32'(strobes()), 32'(S_T0));
    check("rst4.r_in", 32'(bus.R_in), 32'h0);
    check("rst4.r_out", 32'(bus.R_out), 32'h0);
    check("rst4.alu", 32'(bus.alu_instruction), 32'h0);
    check("rst4.count", 32'(bus.instr_count), 32'h0);
    @(negedge clk);
    check("rst4.hold", 32'(strobes()), 32'(S_T0));
    clr = 1'b1;

    // counter wrap: preload 0xFFFF retired, then one nop
    bus.IR_Data = mk_ir(5'b11010, 4'd0, 4'd0, 4'd0);
    force dut.count_q = 16'hFFFF;
    #1;
    release dut.count_q;
    check("wrap.preload", 32'(bus.instr_count), 32'h0000FFFF);
    fetch("wrap");
    cyc("wrap.t3", S_NONE, 16'h0, 16'h0, 5'd0);
    check("wrap.count", 32'(bus.instr_count), 32'h0);

    // halt, then reset recovery
    bus.IR_Data = mk_ir(5'b11011, 4'd0, 4'd0, 4'd0);
    fetch("halt");
    check("halt.run_t3", 32'(bus.run), 32'h1);
    cyc("halt.t3", S_NONE, 16'h0, 16'h0, 5'd0);
    for (int i = 0; i < 3; i++) begin
      check("halt.run", 32'(bus.run), 32'h0);
      cyc("halt.idle", S_NONE, 16'h0, 16'h0, 5'd0);
    end
    check("halt.count", 32'(bus.instr_count), 32'd1);
    clr = 1'b0;
    #1;
    check("halt.rst_strobes", 32'(strobes()), 32'(S_T0));
    check("halt.rst_run", 32'(bus.run), 32'h1);
    check("halt.rst_count", 32'(bus.instr_count), 32'h0);
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    check("halt.restart_t1", 32'(strobes()), 32'(S_T1));

    excl_on = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
